// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue slot: ALU opcode encoding and the
// RV32I major opcodes it decodes.
package alu_issue_pkg;

    localparam int CPU_WIDTH_G    = 32;
    localparam int ALU_OP_WIDTH_G = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // alt selects the funct7[5] flavour (SUB for 000, SRA for 101).
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I decode into ALU opcode and operands; no arithmetic here,
// immediates are only sign-extended.
module alu_issue_dec
    import alu_issue_pkg::*;
#(
    parameter int CPU_WIDTH    = CPU_WIDTH_G,
    parameter int ALU_OP_WIDTH = ALU_OP_WIDTH_G
) (
    input  logic [31:0]              inst,
    input  logic [CPU_WIDTH-1:0]     pc,
    input  logic [CPU_WIDTH-1:0]     rs1,
    input  logic [CPU_WIDTH-1:0]     rs2,
    output logic [ALU_OP_WIDTH-1:0]  op,
    output logic [CPU_WIDTH-1:0]     src1,
    output logic [CPU_WIDTH-1:0]     src2,
    output logic                     illegal
);

    logic [6:0]           opc;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [CPU_WIDTH-1:0] imm_i;
    logic [CPU_WIDTH-1:0] imm_s;
    logic [CPU_WIDTH-1:0] imm_u;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = CPU_WIDTH'($signed(inst[31:20]));
    assign imm_s = CPU_WIDTH'($signed({inst[31:25], inst[11:7]}));
    assign imm_u = CPU_WIDTH'($signed({inst[31:12], 12'b0}));

    always_comb begin
        op      = ALU_ADD;
        src1    = '0;
        src2    = '0;
        illegal = 1'b0;
        case (opc)
            OPC_OP: begin
                src1 = rs1;
                src2 = rs2;
                if (f7 == 7'b0000000) begin
                    op = f3_to_op(f3, 1'b0);
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    op = f3_to_op(f3, 1'b1);
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                src1 = rs1;
                src2 = imm_i;
                // Shift-immediates reuse imm[11:5] as funct7; only bit 30 may be set, and only for SRAI.
                if (f3 == 3'b001) begin
                    op      = ALU_SLL;
                    illegal = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    op      = f3_to_op(f3, inst[30]);
                    illegal = ({inst[31], inst[29:25]} != 6'b0);
                end else begin
                    op = f3_to_op(f3, 1'b0);
                end
            end
            OPC_LUI: begin
                src2 = imm_u;
            end
            OPC_AUIPC: begin
                src1 = pc;
                src2 = imm_u;
            end
            OPC_LOAD: begin
                src1 = rs1;
                src2 = imm_i;
            end
            OPC_STORE: begin
                src1 = rs1;
                src2 = imm_s;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            op   = ALU_ADD;
            src1 = '0;
            src2 = '0;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Issue slot in front of the ALU: decodes one instruction and holds it in a
// valid/ready register backed by a one-entry skid register.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int CPU_WIDTH    = CPU_WIDTH_G,
    parameter int ALU_OP_WIDTH = ALU_OP_WIDTH_G
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [CPU_WIDTH-1:0]     in_pc,
    input  logic [CPU_WIDTH-1:0]     in_rs1,
    input  logic [CPU_WIDTH-1:0]     in_rs2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ALU_OP_WIDTH-1:0]  alu_op,
    output logic [CPU_WIDTH-1:0]     alu_src1,
    output logic [CPU_WIDTH-1:0]     alu_src2,
    output logic [31:0]              out_inst,
    output logic                     illegal
);

    logic [ALU_OP_WIDTH-1:0] dec_op_p0;
    logic [CPU_WIDTH-1:0]    dec_src1_p0;
    logic [CPU_WIDTH-1:0]    dec_src2_p0;
    logic                    dec_illegal_p0;

    logic                    vld_p1;
    logic [ALU_OP_WIDTH-1:0] main_op_p1;
    logic [CPU_WIDTH-1:0]    main_src1_p1;
    logic [CPU_WIDTH-1:0]    main_src2_p1;
    logic [31:0]             main_inst_p1;
    logic                    main_illegal_p1;

    logic                    skid_vld_p1;
    logic [ALU_OP_WIDTH-1:0] skid_op_p1;
    logic [CPU_WIDTH-1:0]    skid_src1_p1;
    logic [CPU_WIDTH-1:0]    skid_src2_p1;
    logic [31:0]             skid_inst_p1;
    logic                    skid_illegal_p1;

    logic accept;
    logic main_free;

    alu_issue_dec #(
        .CPU_WIDTH    (CPU_WIDTH),
        .ALU_OP_WIDTH (ALU_OP_WIDTH)
    ) u_dec (
        .inst    (in_inst),
        .pc      (in_pc),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .op      (dec_op_p0),
        .src1    (dec_src1_p0),
        .src2    (dec_src2_p0),
        .illegal (dec_illegal_p0)
    );

    // in_ready comes straight from skid state so it never sees out_ready combinationally.
    assign in_ready  = !skid_vld_p1;
    assign accept    = in_valid && in_ready;
    assign main_free = !vld_p1 || out_ready;

    // ---- p0 -> p1: decoded operands enter main or skid register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1          <= 1'b0;
            main_op_p1      <= ALU_ADD;
            main_src1_p1    <= '0;
            main_src2_p1    <= '0;
            main_inst_p1    <= '0;
            main_illegal_p1 <= 1'b0;
            skid_vld_p1     <= 1'b0;
            skid_op_p1      <= ALU_ADD;
            skid_src1_p1    <= '0;
            skid_src2_p1    <= '0;
            skid_inst_p1    <= '0;
            skid_illegal_p1 <= 1'b0;
        end else if (main_free) begin
            if (skid_vld_p1) begin
                vld_p1          <= 1'b1;
                main_op_p1      <= skid_op_p1;
                main_src1_p1    <= skid_src1_p1;
                main_src2_p1    <= skid_src2_p1;
                main_inst_p1    <= skid_inst_p1;
                main_illegal_p1 <= skid_illegal_p1;
                skid_vld_p1     <= accept;
                if (accept) begin
                    skid_op_p1      <= dec_op_p0;
                    skid_src1_p1    <= dec_src1_p0;
                    skid_src2_p1    <= dec_src2_p0;
                    skid_inst_p1    <= in_inst;
                    skid_illegal_p1 <= dec_illegal_p0;
                end
            end else begin
                vld_p1 <= accept;
                if (accept) begin
                    main_op_p1      <= dec_op_p0;
                    main_src1_p1    <= dec_src1_p0;
                    main_src2_p1    <= dec_src2_p0;
                    main_inst_p1    <= in_inst;
                    main_illegal_p1 <= dec_illegal_p0;
                end
            end
        end else if (accept) begin
            skid_vld_p1     <= 1'b1;
            skid_op_p1      <= dec_op_p0;
            skid_src1_p1    <= dec_src1_p0;
            skid_src2_p1    <= dec_src2_p0;
            skid_inst_p1    <= in_inst;
            skid_illegal_p1 <= dec_illegal_p0;
        end
    end

    // ---- p1: main register drives the ALU ----
    assign out_valid = vld_p1;
    assign alu_op    = main_op_p1;
    assign alu_src1  = main_src1_p1;
    assign alu_src2  = main_src2_p1;
    assign out_inst  = main_inst_p1;
    assign illegal   = main_illegal_p1;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a driver pushes expected ALU operands when an
// instruction is accepted; a monitor pops and compares on each output transfer.
module tb_alu_issue;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] inst;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] out_inst;
    logic        illegal;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_bp = 1'b0;
    bit   prev_stall = 1'b0;
    exp_t prev_out;
    bit   bp_done;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .alu_src1  (alu_src1),
        .alu_src2  (alu_src2),
        .out_inst  (out_inst),
        .illegal   (illegal)
    );

    function automatic exp_t mk(input logic [3:0] op, input logic [31:0] s1, s2, i, input logic ill);
        exp_t e;
        e.op = op; e.s1 = s1; e.s2 = s2; e.inst = i; e.ill = ill;
        return e;
    endfunction

    // Reference decode straight from the RV32I field definitions.
    function automatic exp_t model(input logic [31:0] i, pc, a, b);
        logic [3:0]  f3map [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
        logic [2:0]  f3  = i[14:12];
        logic [6:0]  f7  = i[31:25];
        logic [31:0] imm_i = {{20{i[31]}}, i[31:20]};
        logic [31:0] imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
        logic [31:0] imm_u = {i[31:12], 12'h000};
        exp_t e;
        e = mk(4'd0, 32'h0, 32'h0, i, 1'b1);
        case (i[6:0])
            7'h33: begin
                if (f7 == 7'h00)                 e = mk(f3map[f3], a, b, i, 1'b0);
                else if (f7 == 7'h20 && f3 == 0) e = mk(4'd1, a, b, i, 1'b0);
                else if (f7 == 7'h20 && f3 == 5) e = mk(4'd7, a, b, i, 1'b0);
            end
            7'h13: begin
                if (f3 == 3'd1) begin
                    if (f7 == 7'h00) e = mk(4'd5, a, imm_i, i, 1'b0);
                end else if (f3 == 3'd5) begin
                    if (f7 == 7'h00)      e = mk(4'd6, a, imm_i, i, 1'b0);
                    else if (f7 == 7'h20) e = mk(4'd7, a, imm_i, i, 1'b0);
                end else begin
                    e = mk(f3map[f3], a, imm_i, i, 1'b0);
                end
            end
            7'h37: e = mk(4'd0, 32'h0, imm_u, i, 1'b0);
            7'h17: e = mk(4'd0, pc, imm_u, i, 1'b0);
            7'h03: e = mk(4'd0, a, imm_i, i, 1'b0);
            7'h23: e = mk(4'd0, a, imm_s, i, 1'b0);
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom;
        logic [6:0]  opcs [6] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23};
        int k = $urandom_range(0, 9);
        if (k < 6) r[6:0] = opcs[k];
        else if (k < 8) r[6:0] = (k == 6) ? 7'h33 : 7'h13;
        if (r[6:0] == 7'h33 || (r[6:0] == 7'h13 && r[13:12] == 2'b01)) begin
            case ($urandom_range(0, 3))
                0, 1:    r[31:25] = 7'h00;
                2:       r[31:25] = 7'h20;
                default: ;
            endcase
        end
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [31:0] i, pc, a, b, input exp_t e);
        int n = 0;
        in_valid = 1'b1; in_inst = i; in_pc = pc; in_rs1 = a; in_rs2 = b;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout inst=%08h in_ready=%0b required=1", i, in_ready);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        exp_t got, e;
        #1;
        got = mk(alu_op, alu_src1, alu_src2, out_inst, illegal);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || got != prev_out) begin
                    errors++;
                    $display("FAIL hold_stable got vld=%0b %h required vld=1 %h", out_valid, got, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got inst=%08h required no output", out_inst);
                end else begin
                    e = sb.pop_front();
                    if (got != e) begin
                        errors++;
                        $display("FAIL output inst=%08h got op=%0d s1=%08h s2=%08h ill=%0b required op=%0d s1=%08h s2=%08h ill=%0b inst=%08h",
                                 out_inst, alu_op, alu_src1, alu_src2, illegal, e.op, e.s1, e.s2, e.ill, e.inst);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = got;
        end
    end

    task automatic check(input string name, input logic [31:0] got, req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%08h required=%08h", name, got, req);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 0; in_rs1 = 5; in_rs2 = 7;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_op", alu_op, 0);
        check("rst_src1", alu_src1, 0);
        check("rst_src2", alu_src2, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_illegal", illegal, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);

        send(32'h002081B3, 0, 5, 7, mk(0, 5, 7, 32'h002081B3, 0));
        #2;
        check("latency_out_valid", out_valid, 1);
        check("latency_out_inst", out_inst, 32'h002081B3);
        @(negedge clk);
        send(32'h402081B3, 0, 5, 7, mk(1, 5, 7, 32'h402081B3, 0));
        send(32'hFFF08093, 0, 10, 3, mk(0, 10, 32'hFFFFFFFF, 32'hFFF08093, 0));
        send(32'h4030D093, 0, 32'h80000000, 0, mk(7, 32'h80000000, 32'h00000403, 32'h4030D093, 0));
        send(32'h12345037, 0, 9, 9, mk(0, 0, 32'h12345000, 32'h12345037, 0));
        send(32'h00001097, 32'h100, 9, 9, mk(0, 32'h100, 32'h1000, 32'h00001097, 0));
        send(32'h00208463, 4, 1, 2, mk(0, 0, 0, 32'h00208463, 1));
        send(32'h022081B3, 4, 1, 2, mk(0, 0, 0, 32'h022081B3, 1));
        drain(20);

        // Backpressure: two accepted, the third waits with in_valid high until out_ready rises.
        out_ready = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    logic [31:0] i = rand_inst();
                    logic [31:0] pc = $urandom, a = $urandom, b = $urandom;
                    send(i, pc, a, b, model(i, pc, a, b));
                end
                bp_done = 1'b1;
            end
        join_none
        repeat (5) @(negedge clk);
        check("bp_accepted", sb.size(), 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_in_valid_waiting", in_valid, 1);
        out_ready = 1'b1;
        for (int n = 0; n < 50 && !bp_done; n++) @(negedge clk);
        check("bp_sender_done", bp_done, 1);
        drain(20);

        // Reset with both entries occupied discards them.
        out_ready = 1'b0;
        send(32'h00500093, 0, 1, 1, model(32'h00500093, 0, 1, 1));
        send(32'h00600093, 0, 1, 1, model(32'h00600093, 0, 1, 1));
        check("full_in_ready", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        #2;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        rand_bp = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic [31:0] i = rand_inst();
            logic [31:0] pc = $urandom, a = $urandom, b = $urandom;
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            send(i, pc, a, b, model(i, pc, a, b));
        end
        drain(2000);
        rand_bp = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
